// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Define LSU_MISALIGNED_SPLIT_EN to allow misaligned accesses (split across two words when needed).
module lsu_dmem_ctrl #(
    parameter int XLEN      = 32,
    parameter int DMEM_SIZE = 4096,
    localparam int AW       = $clog2(DMEM_SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_width,
    input  logic            req_unsigned,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [AW-3:0]   mem_addr,
    output logic            mem_we,
    output logic            mem_re,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and resp_valid
    // is a single-cycle pulse in DONE carrying resp_rdata/resp_fault.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ0 = 3'd1,
        S_RSP0 = 3'd2,
        S_REQ1 = 3'd3,
        S_RSP1 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      req_off;
    logic [2:0]      req_size;
    logic [3:0]      size_mask;
    logic            width_ok;
    logic [XLEN:0]   last_byte;
    logic            out_of_range;
    logic            misaligned;
    logic            cross_raw;
    logic            req_fault;
    logic            req_cross;
    logic [7:0]      be_full;
    logic            accept;

    logic            wr_q;
    logic [1:0]      off_q;
    logic [AW-3:0]   waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be0_q;
    logic [3:0]      be1_q;
    logic [1:0]      width_q;
    logic            uns_q;
    logic            cross_q;
    logic            fault_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_ext;
    logic [5:0]      hi_shift;

    assign req_off = req_addr[1:0];
    assign accept  = (state_q == S_IDLE) && req_valid;

    always_comb begin
        req_size  = 3'd1;
        size_mask = 4'b0001;
        width_ok  = 1'b1;
        case (req_width)
            3'b000: begin req_size = 3'd1; size_mask = 4'b0001; end
            3'b001: begin req_size = 3'd2; size_mask = 4'b0011; end
            3'b010: begin req_size = 3'd4; size_mask = 4'b1111; end
            default: width_ok = 1'b0;
        endcase
    end

    // Wide add so addresses near the top of the 32-bit space cannot wrap.
    assign last_byte    = {1'b0, req_addr} + (XLEN+1)'(req_size) - (XLEN+1)'(1);
    assign out_of_range = last_byte >= (XLEN+1)'(DMEM_SIZE);
    assign misaligned   = ((req_width == 3'b001) && req_off[0]) ||
                          ((req_width == 3'b010) && (req_off != 2'b00));
    assign cross_raw    = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    assign be_full      = {4'b0000, size_mask} << req_off;

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign req_fault = !width_ok || out_of_range;
    assign req_cross = cross_raw && width_ok;
`else
    assign req_fault = !width_ok || out_of_range || misaligned;
    assign req_cross = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= '0;
            be0_q    <= 4'b0000;
            be1_q    <= 4'b0000;
            width_q  <= 2'b00;
            uns_q    <= 1'b0;
            cross_q  <= 1'b0;
            fault_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q     <= req_write;
                off_q    <= req_off;
                waddr_q  <= req_addr[AW-1:2];
                wdata_q  <= req_wdata;
                be0_q    <= be_full[3:0];
                be1_q    <= be_full[7:4];
                width_q  <= req_width[1:0];
                uns_q    <= req_unsigned;
                cross_q  <= req_cross;
                fault_q  <= req_fault;
                result_q <= '0;
            end else if (state_q == S_RSP0) begin
                result_q <= mem_rdata >> {off_q, 3'b000};
            end else if (state_q == S_RSP1) begin
                result_q <= result_q | (mem_rdata << hi_shift);
            end
        end
    end

    // Second-word bytes land above the 4-off bytes taken from the first word.
    assign hi_shift = 6'd32 - {1'b0, off_q, 3'b000};

    always_comb begin
        result_ext = result_q;
        case (width_q)
            2'b00: result_ext = uns_q ? {{(XLEN-8){1'b0}}, result_q[7:0]}
                                      : {{(XLEN-8){result_q[7]}}, result_q[7:0]};
            2'b01: result_ext = uns_q ? {{(XLEN-16){1'b0}}, result_q[15:0]}
                                      : {{(XLEN-16){result_q[15]}}, result_q[15:0]};
            default: result_ext = result_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_fault ? S_DONE : S_REQ0;
            end
            S_REQ0: begin
                mem_we    = wr_q;
                mem_re    = !wr_q;
                mem_addr  = waddr_q;
                mem_be    = be0_q;
                mem_wdata = wdata_q << {off_q, 3'b000};
                if (!wr_q)        state_d = S_RSP0;
                else if (cross_q) state_d = S_REQ1;
                else              state_d = S_DONE;
            end
            S_RSP0: state_d = cross_q ? S_REQ1 : S_DONE;
            S_REQ1: begin
                mem_we    = wr_q;
                mem_re    = !wr_q;
                mem_addr  = waddr_q + (AW-2)'(1);
                mem_be    = be1_q;
                mem_wdata = wdata_q >> hi_shift;
                state_d   = wr_q ? S_DONE : S_RSP1;
            end
            S_RSP1: state_d = S_DONE;
            S_DONE: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (fault_q || wr_q) ? '0 : result_ext;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a behavioural word memory.
// Covers both LSU_MISALIGNED_SPLIT_EN builds.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_width = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    // Results of the most recent do_req call
    int          r_lat;
    int          r_nstrobe;
    logic        r_both;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        s_we    [2];
    logic [9:0]  s_addr  [2];
    logic [3:0]  s_be    [2];
    logic [31:0] s_wdata [2];

    logic [31:0] mem [0:1023];

    lsu_dmem_ctrl #(.XLEN(32), .DMEM_SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] width, input logic uns);
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wdata;
        req_width = width; req_unsigned = uns; req_valid = 1'b1;
        @(posedge clk);
        r_lat = 0; r_nstrobe = 0; r_both = 1'b0; r_rdata = 'x; r_fault = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_we && mem_re) r_both = 1'b1;
            if (mem_we || mem_re) begin
                if (r_nstrobe < 2) begin
                    s_we[r_nstrobe] = mem_we; s_addr[r_nstrobe] = mem_addr;
                    s_be[r_nstrobe] = mem_be; s_wdata[r_nstrobe] = mem_wdata;
                end
                r_nstrobe++;
            end
            if (resp_valid) begin
                r_lat = k; r_rdata = resp_rdata; r_fault = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        compared++;
        if ({req_ready, resp_valid, resp_fault, mem_we, mem_re, mem_be} !== 9'b1_0000_0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {req_ready, resp_valid, resp_fault, mem_we, mem_re, mem_be});
        end
        compared++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 74'd0) begin
            mismatched++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", mem_addr, mem_wdata, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 2 || r_nstrobe !== 1 || r_both !== 1'b0) begin
            mismatched++;
            $display("FAIL st_word_timing: lat %0d strobes %0d both %b want 2 1 0", r_lat, r_nstrobe, r_both);
        end
        compared++;
        if ({s_we[0], s_addr[0], s_be[0], s_wdata[0]} !== {1'b1, 10'd4, 4'b1111, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL st_word_req0: we %b addr %0d be %b wdata %h want 1 4 1111 deadbeef",
                     s_we[0], s_addr[0], s_be[0], s_wdata[0]);
        end
        compared++;
        if (r_rdata !== 32'h0 || r_fault !== 1'b0) begin
            mismatched++;
            $display("FAIL st_word_resp: rdata %h fault %b want 0 0", r_rdata, r_fault);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 3 || r_rdata !== 32'hDEADBEEF || r_fault !== 1'b0 || s_we[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL ld_word: lat %0d rdata %h fault %b we %b want 3 deadbeef 0 0",
                     r_lat, r_rdata, r_fault, s_we[0]);
        end
        do_req(1'b0, 32'hFFC, 32'h0, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 3 || r_rdata !== 32'h12345678 || r_fault !== 1'b0) begin
            mismatched++;
            $display("FAIL ld_word_top: lat %0d rdata %h fault %b want 3 12345678 0", r_lat, r_rdata, r_fault);
        end
    endtask

    task automatic test_extend();
        logic [31:0] exp_v [5];
        logic [31:0] addr_v [5];
        logic [2:0]  wid_v [5];
        logic        uns_v [5];
        addr_v = '{32'h20, 32'h23, 32'h22, 32'h22, 32'h21};
        wid_v  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
        uns_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v  = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, addr_v[i], 32'h0, wid_v[i], uns_v[i]);
            compared++;
            if (r_rdata !== exp_v[i] || r_lat !== 3 || s_be[0] === 4'b0000) begin
                mismatched++;
                $display("FAIL ld_ext_%0d: rdata %h lat %0d be %b want %h 3", i, r_rdata, r_lat, s_be[0], exp_v[i]);
            end
        end
        do_req(1'b1, 32'h21, 32'h000000AA, 3'b000, 1'b0);
        compared++;
        if ({s_be[0], s_wdata[0], s_addr[0]} !== {4'b0010, 32'h0000AA00, 10'd8} || r_lat !== 2) begin
            mismatched++;
            $display("FAIL st_byte: be %b wdata %h addr %0d lat %0d want 0010 0000aa00 8 2",
                     s_be[0], s_wdata[0], s_addr[0], r_lat);
        end
        do_req(1'b0, 32'h20, 32'h0, 3'b001, 1'b0);
        compared++;
        if (r_rdata !== 32'hFFFFAA81) begin
            mismatched++;
            $display("FAIL ld_after_st_byte: rdata %h want ffffaa81", r_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int resp_at[2];
        int nresp;
        logic ready_bad;
        logic [31:0] exp_v;
        nresp = 0; ready_bad = 1'b0;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_width = 3'b010; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((k == 4) ? (req_ready !== 1'b1) : (k <= 7 && req_ready !== 1'b0)) ready_bad = 1'b1;
            if (resp_valid) begin
                if (nresp < 2) resp_at[nresp] = k;
                nresp++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                compared++;
                if (resp_rdata !== exp_v) begin
                    mismatched++;
                    $display("FAIL b2b_data: rdata %h want %h", resp_rdata, exp_v);
                end
            end
            if (k == 5) req_valid = 1'b0;
        end
        compared++;
        if (nresp !== 2 || resp_at[0] !== 3 || resp_at[1] !== 7) begin
            mismatched++;
            $display("FAIL b2b_timing: resps %0d at %0d,%0d want 2 at 3,7", nresp, resp_at[0], resp_at[1]);
        end
        compared++;
        if (ready_bad !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_ready: req_ready wrong during/after first transaction (got bad=%b want 0)", ready_bad);
        end
    endtask

    task automatic test_faults();
        do_req(1'b0, 32'h10, 32'h0, 3'b011, 1'b0);
        compared++;
        if (r_lat !== 1 || r_fault !== 1'b1 || r_nstrobe !== 0 || r_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL fault_width: lat %0d fault %b strobes %0d rdata %h want 1 1 0 0",
                     r_lat, r_fault, r_nstrobe, r_rdata);
        end
        do_req(1'b0, 32'd4094, 32'h0, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 1 || r_fault !== 1'b1 || r_nstrobe !== 0) begin
            mismatched++;
            $display("FAIL fault_range: lat %0d fault %b strobes %0d want 1 1 0", r_lat, r_fault, r_nstrobe);
        end
        do_req(1'b0, 32'h1, 32'h0, 3'b001, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        compared++;
        if (r_lat !== 3 || r_fault !== 1'b0 || r_rdata !== 32'hFFFFFEBA || s_be[0] !== 4'b0110) begin
            mismatched++;
            $display("FAIL mis_half: lat %0d fault %b rdata %h be %b want 3 0 fffffeba 0110",
                     r_lat, r_fault, r_rdata, s_be[0]);
        end
`else
        compared++;
        if (r_lat !== 1 || r_fault !== 1'b1 || r_nstrobe !== 0 || r_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL fault_mis_half: lat %0d fault %b strobes %0d rdata %h want 1 1 0 0",
                     r_lat, r_fault, r_nstrobe, r_rdata);
        end
`endif
    endtask

    task automatic test_split();
`ifdef LSU_MISALIGNED_SPLIT_EN
        do_req(1'b1, 32'h0E, 32'h11223344, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 3 || r_nstrobe !== 2 || r_both !== 1'b0) begin
            mismatched++;
            $display("FAIL split_st_timing: lat %0d strobes %0d both %b want 3 2 0", r_lat, r_nstrobe, r_both);
        end
        compared++;
        if ({s_we[0], s_addr[0], s_be[0], s_wdata[0]} !== {1'b1, 10'd3, 4'b1100, 32'h33440000}) begin
            mismatched++;
            $display("FAIL split_st_req0: we %b addr %0d be %b wdata %h want 1 3 1100 33440000",
                     s_we[0], s_addr[0], s_be[0], s_wdata[0]);
        end
        compared++;
        if ({s_we[1], s_addr[1], s_be[1], s_wdata[1]} !== {1'b1, 10'd4, 4'b0011, 32'h00001122}) begin
            mismatched++;
            $display("FAIL split_st_req1: we %b addr %0d be %b wdata %h want 1 4 0011 00001122",
                     s_we[1], s_addr[1], s_be[1], s_wdata[1]);
        end
        do_req(1'b0, 32'h0E, 32'h0, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 5 || r_rdata !== 32'h11223344 || r_fault !== 1'b0 || r_nstrobe !== 2) begin
            mismatched++;
            $display("FAIL split_ld_word: lat %0d rdata %h fault %b strobes %0d want 5 11223344 0 2",
                     r_lat, r_rdata, r_fault, r_nstrobe);
        end
        do_req(1'b0, 32'h0F, 32'h0, 3'b001, 1'b0);
        compared++;
        if (r_lat !== 5 || r_rdata !== 32'h00002233) begin
            mismatched++;
            $display("FAIL split_ld_half: lat %0d rdata %h want 5 00002233", r_lat, r_rdata);
        end
`else
        do_req(1'b1, 32'h0E, 32'h11223344, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 1 || r_fault !== 1'b1 || r_nstrobe !== 0) begin
            mismatched++;
            $display("FAIL fault_mis_st: lat %0d fault %b strobes %0d want 1 1 0", r_lat, r_fault, r_nstrobe);
        end
        do_req(1'b0, 32'h0F, 32'h0, 3'b001, 1'b0);
        compared++;
        if (r_lat !== 1 || r_fault !== 1'b1 || r_nstrobe !== 0) begin
            mismatched++;
            $display("FAIL fault_mis_ld: lat %0d fault %b strobes %0d want 1 1 0", r_lat, r_fault, r_nstrobe);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_write = 1'b0; req_width = 3'b010; req_unsigned = 1'b0; req_valid = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_addr = 32'h0E;
`else
        req_addr = 32'h10;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        compared++;
        if (mem_re !== 1'b1 || req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_inflight: re %b ready %b want 1 0", mem_re, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({mem_re, mem_we, resp_valid, req_ready, mem_be} !== 8'b0001_0000) begin
            mismatched++;
            $display("FAIL rst_mid_abort: re %b we %b valid %b ready %b be %b want 0 0 0 1 0000",
                     mem_re, mem_we, resp_valid, req_ready, mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
        compared++;
        if (r_lat !== 3 || r_rdata !== 32'h80FFAA81 || r_fault !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_after: lat %0d rdata %h fault %b want 3 80ffaa81 0", r_lat, r_rdata, r_fault);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'hCAFEBABE;
        mem[8]    = 32'h80FF7F81;
        mem[1023] = 32'h12345678;
        test_reset();
        test_aligned();
        test_extend();
        test_back_to_back();
        test_faults();
        test_split();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store unit on the core side of the data memory interface. It accepts one load or store per transaction from the execute stage and issues word-aligned accesses with byte enables to the data memory. For loads it extracts the addressed bytes and sign- or zero-extends them. It stalls the core while a transaction is in flight and flags illegal accesses.

Parameters:
XLEN, 32, data width; fixed to 32 in this revision.
DMEM_SIZE, 4096, data memory size in bytes; power of two, at least 8.
AW, $clog2(DMEM_SIZE), byte address width (localparam).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request; core holds all req_* stable until accepted
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge
req_write  in  1  1 = store, 0 = load
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-aligned
req_width  in  3  000 = byte, 001 = half, 010 = word; all other codes illegal
req_unsigned  in  1  zero-extend byte/half loads; ignored for word
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  load result; 0 for stores and faults
resp_fault  out  1  qualified by resp_valid; access was illegal
mem_addr  out  AW-2  word address
mem_we  out  1  write strobe
mem_re  out  1  read strobe
mem_be  out  4  byte enables; bit i = byte lane i (little-endian)
mem_wdata  out  XLEN  lane-aligned write data
mem_rdata  in  XLEN  read data, valid the cycle after mem_re

Behaviour:
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE. Encode as registers; decode the mem_* strobes from state.
- Decode on accept:
  - off = req_addr[1:0].
  - size = 1, 2 or 4 bytes.
  - misaligned = (half & off[0]) | (word & off != 0).
  - cross = off + size > 4.
- Fault on accept when any of these hold:
  - width code illegal;
  - req_addr + size - 1 >= DMEM_SIZE (addresses never wrap);
  - misaligned, and the macro is undefined.
- Fault path: IDLE -> DONE. No mem strobe is issued. In DONE, resp_fault = 1 and resp_rdata = 0.
- REQ0:
  - mem_re = !write, mem_we = write.
  - mem_addr = addr[AW-1:2].
  - mem_be = bytes off .. min(off+size, 4) - 1.
  - mem_wdata = wdata << 8*off.
- REQ0 next state:
  - load -> RSP0;
  - store -> REQ1 if cross, else DONE.
- RSP0: capture the mem_rdata bytes for lanes in mem_be into result bytes 0..(4-off-1). Next state: REQ1 if cross, else DONE.
- REQ1:
  - mem_addr = word address + 1.
  - mem_be = lanes 0 .. off+size-5.
  - mem_wdata = wdata >> 8*(4-off).
  - Next state: load -> RSP1; store -> DONE.
- RSP1: capture the remaining bytes into the upper result bytes, then go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle.
  - resp_rdata is the assembled value, sign-extended from bit 8*size-1 unless unsigned or word.
  - Next state: IDLE.
- Latency, counted in cycles after the accept edge, resp_valid asserted in:
  - aligned store: cycle 2;
  - aligned load: cycle 3;
  - split store: cycle 3;
  - split load: cycle 5;
  - fault: cycle 1.
- mem_re and mem_we are never high together. Exactly one strobe is high in REQ0/REQ1 and none in other states.
- req_valid while not in IDLE is ignored. Earliest next accept is the cycle after DONE.
- Reset values (asynchronous, immediate): state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, mem_we 0, mem_re 0, mem_be 0, mem_addr 0, mem_wdata 0.
- Reset mid-transaction aborts it. Any partial split store is not rolled back.

Optional Feature:
LSU_MISALIGNED_SPLIT_EN:
- Defined: misaligned accesses are legal. Accesses within one word use a single access with shifted byte enables. Word-crossing accesses are split into REQ0/REQ1 as above.
- Undefined: any misaligned access faults, REQ1/RSP1 are unreachable, and cross is forced to 0.

Test Plan:
- Aligned store then load: store word 0xDEADBEEF @0x10 -> REQ0 has mem_we=1, mem_addr=4, mem_be=1111, resp_valid in cycle 2. Load word @0x10 -> resp_rdata=0xDEADBEEF in cycle 3, resp_fault=0.
- Byte/half extension: memory word @0x20 = 0x80FF7F81.
  - Load byte signed @0x20 -> 0xFFFFFF81.
  - Load byte unsigned @0x23 -> 0x00000080.
  - Load half signed @0x22 -> 0xFFFF80FF.
  - Store byte 0xAA @0x21 -> mem_be=0010, mem_wdata=0x0000AA00.
- Split word (macro on): store 0x11223344 @0x0E ->
  - REQ0: addr 3, be=1100, wdata=0x33440000.
  - REQ1: addr 4, be=0011, wdata=0x00001122.
  - Load word @0x0E -> 0x11223344, resp_valid in cycle 5.
- Faults: load half @0x01 with macro off -> resp_fault=1 in cycle 1, no strobe. Width 011 -> fault. Word load @DMEM_SIZE-2 -> fault in both builds.
- Handshake: hold req_valid continuously for two loads -> second accepted only in the cycle after DONE. req_ready=0 throughout the first transaction.
- Reset: assert rst_n=0 during RSP0 of a split load -> mem_re=0, resp_valid=0, req_ready=1 immediately. After release, a fresh aligned load completes in cycle 3.
